// File: rtl/pop_count_pipe.sv
// Pipelined population counter for TDC thermometer/bubble words.
// Leaf popcounts feed a registered pairwise adder tree; an optional accumulator averages results.
module pop_count_pipe #(
  parameter int N        = 64,
  parameter int LEAF     = 8,
  parameter int ACC_LOG2 = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        x_valid,
  input  logic [N-1:0]                x,
  input  logic                        acc_clear,
  output logic [$clog2(N):0]          y,
  output logic                        y_valid,
  output logic [$clog2(N)+ACC_LOG2:0] acc,
  output logic                        acc_valid
);

  localparam int NL     = N / LEAF;
  localparam int LEVELS = $clog2(NL);
  localparam int L      = 1 + LEVELS;
  localparam int LW     = $clog2(LEAF) + 1;
  localparam int YW     = $clog2(N) + 1;
  localparam int AW     = YW + ACC_LOG2;

  // Valid/enable contract: x is taken on a clock edge where en=1 and x_valid=1.
  // y_valid and acc_valid are only ever high while en=1; there is no back-pressure
  // beyond en, which freezes every stage so in-flight samples resume unchanged.
  logic [L-1:0] vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (en) begin
      vld[0] <= x_valid;
      for (int k = 1; k < L; k++) begin
        vld[k] <= vld[k-1];
      end
    end
  end

  function automatic logic [LW-1:0] leaf_count(input logic [LEAF-1:0] v);
    logic [LW-1:0] c;
    c = '0;
    for (int k = 0; k < LEAF; k++) begin
      c = c + {{(LW-1){1'b0}}, v[k]};
    end
    return c;
  endfunction

  // Level l holds NL>>l partial counts, each LW+l bits wide, so no sum is ever truncated.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int CNT = NL >> l;
    localparam int WL  = LW + l;

    logic [WL-1:0] d   [CNT];
    logic [WL-1:0] nxt [CNT];
    logic          load;

    if (l == 0) begin : g_leaf
      assign load = en & x_valid;
      for (genvar i = 0; i < CNT; i++) begin : g_cnt
        assign nxt[i] = leaf_count(x[i*LEAF +: LEAF]);
      end
    end else begin : g_add
      assign load = en & vld[l-1];
      for (genvar i = 0; i < CNT; i++) begin : g_sum
        assign nxt[i] = {1'b0, g_lvl[l-1].d[2*i]} + {1'b0, g_lvl[l-1].d[2*i+1]};
      end
    end

    // Data only moves with a valid sample, so the last stage holds the last real result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < CNT; i++) begin
          d[i] <= '0;
        end
      end else if (load) begin
        for (int i = 0; i < CNT; i++) begin
          d[i] <= nxt[i];
        end
      end
    end
  end

  assign y       = g_lvl[LEVELS].d[0];
  assign y_valid = vld[L-1] & en;

  logic [AW-1:0]       acc_sum;
  logic [ACC_LOG2-1:0] cnt;
  logic                acc_pulse;
  logic [AW-1:0]       y_ext;

  assign y_ext = {{ACC_LOG2{1'b0}}, y};

  // acc_clear wins over a coincident result; the pulse register is only consumed on enabled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_sum   <= '0;
      cnt       <= '0;
      acc       <= '0;
      acc_pulse <= 1'b0;
    end else if (en) begin
      acc_pulse <= 1'b0;
      if (acc_clear) begin
        acc_sum <= '0;
        cnt     <= '0;
      end else if (vld[L-1]) begin
        if (&cnt) begin
          acc       <= acc_sum + y_ext;
          acc_sum   <= '0;
          acc_pulse <= 1'b1;
        end else begin
          acc_sum <= acc_sum + y_ext;
        end
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign acc_valid = acc_pulse & en;

endmodule

// File: tb/tb_pop_count_pipe.sv
// Bench for pop_count_pipe: directed vectors on the default build plus a timestamp-based
// reference model checking four parameterisations cycle by cycle under random traffic.
module tb_pop_count_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         en;
  logic         x_valid;
  logic         acc_clear;
  logic [127:0] xw;

  logic [6:0]  y0;  logic yv0; logic [10:0] acc0; logic av0;
  logic [6:0]  y1;  logic yv1; logic [10:0] acc1; logic av1;
  logic [7:0]  y2;  logic yv2; logic [11:0] acc2; logic av2;
  logic [4:0]  y3;  logic yv3; logic [8:0]  acc3; logic av3;

  pop_count_pipe #(.N(64), .LEAF(8), .ACC_LOG2(4)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .x_valid(x_valid), .x(xw[63:0]), .acc_clear(acc_clear),
    .y(y0), .y_valid(yv0), .acc(acc0), .acc_valid(av0));
  pop_count_pipe #(.N(64), .LEAF(64), .ACC_LOG2(4)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .x_valid(x_valid), .x(xw[63:0]), .acc_clear(acc_clear),
    .y(y1), .y_valid(yv1), .acc(acc1), .acc_valid(av1));
  pop_count_pipe #(.N(128), .LEAF(4), .ACC_LOG2(4)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .x_valid(x_valid), .x(xw), .acc_clear(acc_clear),
    .y(y2), .y_valid(yv2), .acc(acc2), .acc_valid(av2));
  pop_count_pipe #(.N(16), .LEAF(2), .ACC_LOG2(4)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en), .x_valid(x_valid), .x(xw[15:0]), .acc_clear(acc_clear),
    .y(y3), .y_valid(yv3), .acc(acc3), .acc_valid(av3));

  int n_checks;
  int n_errors;

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: every enabled edge gets a timestamp; the result of the sample taken at
  // enabled edge k is visible once L enabled edges (including edge k) have elapsed.
  int md_n[4] = '{64, 64, 128, 16};
  int md_l[4] = '{4, 1, 6, 4};
  int m_e[4];
  bit m_hv[4][16];
  int m_hc[4][16];
  int m_y[4];
  int m_sum[4];
  int m_cnt[4];
  int m_acc[4];
  bit m_pulse[4];

  function automatic int pc(input int d, input logic [127:0] v);
    logic [127:0] m;
    m = (128'd1 << md_n[d]) - 128'd1;
    return $countones(v & m);
  endfunction

  function automatic bit vis(input int d, output int c);
    int idx;
    idx = m_e[d] - md_l[d] + 1;
    c = 0;
    if (idx < 1) return 1'b0;
    c = m_hc[d][idx % 16];
    return m_hv[d][idx % 16];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      m_e[d] = 0; m_y[d] = 0; m_sum[d] = 0; m_cnt[d] = 0; m_acc[d] = 0; m_pulse[d] = 1'b0;
      for (int i = 0; i < 16; i++) begin
        m_hv[d][i] = 1'b0;
        m_hc[d][i] = 0;
      end
    end
  endtask

  task automatic model_edge();
    bit v;
    int c;
    for (int d = 0; d < 4; d++) begin
      v = vis(d, c);
      m_pulse[d] = 1'b0;
      if (acc_clear) begin
        m_sum[d] = 0;
        m_cnt[d] = 0;
      end else if (v) begin
        m_sum[d] += m_y[d];
        m_cnt[d] += 1;
        if (m_cnt[d] == 16) begin
          m_acc[d]   = m_sum[d];
          m_pulse[d] = 1'b1;
          m_sum[d]   = 0;
          m_cnt[d]   = 0;
        end
      end
      m_e[d] += 1;
      m_hv[d][m_e[d] % 16] = x_valid;
      m_hc[d][m_e[d] % 16] = pc(d, xw);
      if (vis(d, c)) m_y[d] = c;
    end
  endtask

  function automatic longint out_y(input int d);
    case (d)
      0: return longint'(y0);
      1: return longint'(y1);
      2: return longint'(y2);
      default: return longint'(y3);
    endcase
  endfunction
  function automatic longint out_yv(input int d);
    case (d)
      0: return longint'(yv0);
      1: return longint'(yv1);
      2: return longint'(yv2);
      default: return longint'(yv3);
    endcase
  endfunction
  function automatic longint out_acc(input int d);
    case (d)
      0: return longint'(acc0);
      1: return longint'(acc1);
      2: return longint'(acc2);
      default: return longint'(acc3);
    endcase
  endfunction
  function automatic longint out_av(input int d);
    case (d)
      0: return longint'(av0);
      1: return longint'(av1);
      2: return longint'(av2);
      default: return longint'(av3);
    endcase
  endfunction

  task automatic model_check();
    bit v;
    int c;
    for (int d = 0; d < 4; d++) begin
      v = vis(d, c);
      chk($sformatf("d%0d_y_valid", d), out_yv(d), longint'(en && v));
      chk($sformatf("d%0d_y", d), out_y(d), longint'(m_y[d]));
      chk($sformatf("d%0d_acc", d), out_acc(d), longint'(m_acc[d]));
      chk($sformatf("d%0d_acc_valid", d), out_av(d), longint'(en && m_pulse[d]));
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (rst_n && en) model_edge();
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) model_check();
  end

  initial forever begin
    @(negedge rst_n);
    model_reset();
  end

  // Scoreboard for accumulator pulses on the default build
  logic [31:0] exp_q[$];
  int          n_pulses;

  task automatic watch_acc();
    if (av0) begin
      n_pulses++;
      if (exp_q.size() == 0) chk("acc_unexpected_pulse", av0, 0);
      else chk("acc_value", acc0, exp_q.pop_front());
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    watch_acc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ten_bits();
    logic [63:0] v;
    v = '0;
    while ($countones(v) < 10) v[$urandom_range(0, 63)] = 1'b1;
    return v;
  endfunction

  typedef struct {
    logic [63:0] x;
    int          exp_y;
  } vec_t;
  vec_t vecs[4];

  int          expsum;
  logic [63:0] r64;
  int          sel;

  initial begin
    vecs[0] = '{64'h0000_0000_0000_0000, 0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64};
    vecs[2] = '{64'h8000_0000_0000_0001, 2};
    vecs[3] = '{64'h5555_5555_5555_5555, 32};

    n_checks = 0; n_errors = 0; n_pulses = 0;
    rst_n = 1'b0; en = 1'b0; x_valid = 1'b0; acc_clear = 1'b0; xw = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_y", y0, 0);
    chk("rst_y_valid", yv0, 0);
    chk("rst_acc", acc0, 0);
    chk("rst_acc_valid", av0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 1'b1;

    // Single sample: result after 4 cycles, then held with y_valid low
    for (int c = 0; c < 8; c++) begin
      x_valid = (c == 0);
      xw = (c == 0) ? 128'h00FF_0000_0000_000F : '0;
      @(negedge clk);
      chk($sformatf("t1_y_valid_c%0d", c), yv0, (c == 4));
      if (c >= 4) chk($sformatf("t1_y_c%0d", c), y0, 12);
      @(posedge clk);
      #1;
    end

    // Back-to-back boundary words
    for (int c = 0; c < 8; c++) begin
      x_valid = (c < 4);
      xw = (c < 4) ? {64'h0, vecs[c].x} : '0;
      @(negedge clk);
      chk($sformatf("t2_y_valid_c%0d", c), yv0, (c >= 4));
      if (c >= 4) chk($sformatf("t2_y_c%0d", c), y0, vecs[c-4].exp_y);
      @(posedge clk);
      #1;
    end

    // Stall for 3 cycles while the sample sits in the first tree level
    for (int c = 0; c < 10; c++) begin
      en = !(c >= 2 && c <= 4);
      x_valid = (c == 0);
      xw = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
      @(negedge clk);
      chk($sformatf("t3_y_valid_c%0d", c), yv0, (c == 7));
      if (c == 7) chk("t3_y", y0, 64);
      @(posedge clk);
      #1;
    end
    en = 1'b1;

    // Accumulate: 16 x popcount 10, then 16 x all-ones
    x_valid = 1'b0; acc_clear = 1'b1;
    cyc();
    acc_clear = 1'b0;
    n_pulses = 0;
    exp_q.push_back(32'd160);
    exp_q.push_back(32'd1024);
    for (int c = 0; c < 32; c++) begin
      x_valid = 1'b1;
      xw = (c < 16) ? {64'h0, ten_bits()} : {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
      cyc();
    end
    x_valid = 1'b0;
    repeat (8) cyc();
    chk("t4_pulse_count", n_pulses, 2);
    chk("t4_queue_left", exp_q.size(), 0);

    // acc_clear collides with the 8th result of a block
    acc_clear = 1'b1;
    cyc();
    n_pulses = 0;
    expsum = 0;
    for (int c = 0; c < 24; c++) begin
      r64 = {$urandom, $urandom};
      x_valid = 1'b1;
      xw = {64'h0, r64};
      acc_clear = (c == 11);
      if (c >= 8) expsum += $countones(r64);
      if (c == 0) exp_q.push_back(32'(expsum));
      cyc();
    end
    exp_q[0] = 32'(expsum);
    x_valid = 1'b0; acc_clear = 1'b0;
    repeat (10) cyc();
    chk("t5_pulse_count", n_pulses, 1);
    chk("t5_queue_left", exp_q.size(), 0);

    // Asynchronous reset with samples in flight
    for (int c = 0; c < 4; c++) begin
      x_valid = (c < 3);
      xw = {$urandom, $urandom, 32'hFFFF_0000, $urandom};
      @(negedge clk);
      if (c == 3) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_y", y0, 0);
        chk("t6_rst_y_valid", yv0, 0);
        chk("t6_rst_acc", acc0, 0);
        chk("t6_rst_acc_valid", av0, 0);
      end
      @(posedge clk);
      #1;
    end
    x_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      x_valid = (c == 6);
      xw = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
      @(negedge clk);
      chk($sformatf("t6_y_valid_c%0d", c), yv0, (c == 10));
      chk($sformatf("t6_y_c%0d", c), y0, (c >= 10) ? 64 : 0);
      @(posedge clk);
      #1;
    end

    // Random traffic across all four builds against the reference model
    for (int c = 0; c < 800; c++) begin
      en = ($urandom_range(0, 9) != 0);
      x_valid = ($urandom_range(0, 3) != 0);
      acc_clear = ($urandom_range(0, 63) == 0);
      sel = $urandom_range(0, 7);
      if (sel == 0) xw = '0;
      else if (sel == 1) xw = '1;
      else xw = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
    end
    en = 1'b1; x_valid = 1'b0; acc_clear = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pop_count_pipe.md
Name: pop_count_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle TDC population counter.
- Splits the N-bit thermometer/bubble word into LEAF-bit groups and counts each group, then sums the groups in a registered binary adder tree.
- Carries a valid bit alongside the data and supports stalls through a global enable.
- Optional accumulator sums 2**ACC_LOG2 consecutive valid counts, giving averaged TDC codes to the readout logic.

Parameters:
- N, 64, input word width; power of two, N >= LEAF.
- LEAF, 8, leaf group width; power of two, 2 <= LEAF <= N.
- ACC_LOG2, 4, log2 of the number of samples summed per accumulated result (1..8).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  pipeline advance; 0 freezes every register except the reset path.
- x_valid  in  1  x carries a sample this cycle.
- x  in  N  input word.
- acc_clear  in  1  synchronous clear of the accumulator and sample counter.
- y  out  $clog2(N)+1  pipelined population count.
- y_valid  out  1  y carries a new result this cycle.
- acc  out  $clog2(N)+1+ACC_LOG2  accumulated sum.
- acc_valid  out  1  one-cycle pulse when acc is updated.

Behaviour:
- Reset (rst_n=0, asynchronous): all stage data, valid bits, y, y_valid, acc, acc_valid and the sample counter go to 0.
- Structure:
  - Stage 0 registers N/LEAF leaf counts, each $clog2(LEAF)+1 bits wide.
  - Each of the log2(N/LEAF) tree levels adds adjacent pairs with the width growing by 1 bit, and is registered.
  - Final width is $clog2(N)+1; no truncation anywhere.
- Latency:
  - L = 1 + log2(N/LEAF) enabled cycles from x to y. N=64, LEAF=8 gives L=4.
  - LEAF=N gives L=1, which is equivalent to the simple counter.
- Valid: a shift chain of L bits travels with the data.
- Stage loading:
  - A stage data register loads only when en=1 and its incoming valid is 1; otherwise it holds.
  - y therefore holds the last valid result.
  - The valid chain shifts on every en=1 cycle.
- Enable: en=0 holds everything, and y_valid and acc_valid are forced to 0 on that cycle. Samples in flight resume unchanged when en returns to 1.
- Back-to-back: one sample per enabled cycle, with no bubbles inserted.
- Accumulator, sampled on each enabled cycle with y_valid=1:
  - acc_sum += y and cnt += 1.
  - When cnt wraps from 2**ACC_LOG2-1 to 0: on the next clock, acc <= acc_sum + y, acc_valid=1 for one cycle, and acc_sum <= 0.
  - acc_sum width equals acc width; overflow is impossible (max N*2**ACC_LOG2).
  - acc holds its value between pulses.
- acc_clear:
  - Zeroes acc_sum and cnt on the next clock; acc keeps its last published value.
  - Has priority over a simultaneous y_valid sample, which is discarded from accumulation (y and y_valid are still output normally).
  - acc_clear during en=0 is ignored.
- Reset mid-operation: all in-flight samples are lost. No y_valid may appear until L enabled cycles after the first post-reset x_valid.
- No X propagation: x bits are treated as data. A bench drives only 0/1.

Test Plan:
- Reset then single sample: release rst_n, x=64'h00FF_0000_0000_000F with x_valid=1, en=1 for 1 cycle -> y_valid=1 exactly 4 cycles later with y=12; y holds 12 afterwards with y_valid=0.
- Streaming boundaries: x = 0, all-ones, 64'h8000_0000_0000_0001, 64'h5555_5555_5555_5555 on consecutive cycles -> y = 0, 64, 2, 32 on 4 consecutive cycles starting at cycle 4.
- Stall: sample x=all-ones, drop en for 3 cycles while it is at stage 1 -> no y_valid during the stall; y=64 appears after 4 enabled cycles total.
- Accumulate: 16 valid samples each with popcount 10 (ACC_LOG2=4) -> single acc_valid pulse with acc=160. Next 16 samples of all-ones -> acc=1024 (max, no overflow).
- Clear collision: assert acc_clear on the same cycle as the 8th y_valid of a block -> that sample is excluded. The next acc_valid occurs after 16 further samples and equals their sum only.
- Async reset mid-stream: pull rst_n low between clock edges with 3 samples in flight -> y, y_valid, acc, acc_valid read 0 immediately. No y_valid appears after release until a new sample has traversed 4 enabled cycles.
- Parameter sweep: repeat the random-stimulus compare against a reference count for (N, LEAF) = (64,8), (64,64), (128,4), (16,2), checking latency 1+log2(N/LEAF).
